updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter: the successor to the team's 3-bit T-controlled up/down counter. It generalises the width and adds a runtime-programmable upper limit, synchronous load and count enable. It also supports a wrap or saturate mode, a registered boundary pulse and a sticky overflow flag. It serves as the general counting primitive for timers, address generators and event counters in the design.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  reset, asynchronous and active-low
- en  in  1  count enable; one step per cycle when high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load of `din`
- din  in  WIDTH  load value
- limit  in  WIDTH  upper bound of count range; range is 0..limit inclusive
- sat  in  1  mode: 0 = wrap, 1 = saturate
- clr_ovf  in  1  synchronous clear of `ovf`
- Q  out  WIDTH  count value (registered)
- bnd  out  1  one-cycle pulse: the previous step hit a range boundary
- ovf  out  1  sticky flag: a boundary crossing occurred since last clear

## Operation
- Priority per cycle: `load` > `en` > hold.
- Load:
  - Q ← min(din, limit).
  - No `bnd`; `ovf` unaffected.
- Enabled up step, Q < limit: Q ← Q+1.
- Enabled up step, Q ≥ limit (boundary):
  - Wrap mode: Q ← 0.
  - Sat mode: Q ← limit.
  - In both modes, `bnd` pulses and `ovf` sets.
- Enabled down step, Q > 0: Q ← Q−1.
- Enabled down step, Q == 0 (boundary):
  - Wrap mode: Q ← limit.
  - Sat mode: Q stays 0.
  - In both modes, `bnd` pulses and `ovf` sets.
- Q > limit can arise when `limit` is lowered at runtime:
  - An up step is treated as a boundary (see above).
  - A down step gives Q−1.
- Q holds when `en`=0 and `load`=0.
- `sat`, `up` and `limit` are sampled every cycle; changing them mid-count takes effect on the next step.
- `limit`=0:
  - Every enabled step is a boundary.
  - Q stays 0 in both modes; `bnd` pulses every enabled cycle.
- Arithmetic is WIDTH-bit unsigned. No intermediate value may exceed WIDTH bits; boundary compare is done before the add or subtract.
- `ovf`:
  - Set by any boundary step.
  - Cleared by `clr_ovf`.
  - If set and clear happen in the same cycle, set wins.

## Timing
- Reset (Resetn=0, asynchronous, immediate): Q=0, bnd=0, ovf=0. All outputs hold these values while Resetn is low.
- Reset release: the first rising edge with Resetn=1 is processed normally.
- Step latency: Q updates on the rising edge where en=1 is sampled; the new value is visible the same cycle after the edge.
- `bnd`:
  - Registered; high exactly in the cycle following the edge that performed the boundary step.
  - Back-to-back boundary steps hold it high continuously.
- `ovf`: becomes 1 on the same edge that drives `bnd` high.
- Load/enable collision: when `load` and `en` are both 1, the load occurs, no step is taken and no `bnd` is produced.
- Reset mid-count: aborts immediately. A pending `bnd` is dropped and `ovf` is cleared.
- No combinational path from any input to any output.

## Test plan
Directed scenarios (WIDTH=4, limit=9 unless stated):
- Reset/hold:
  - Stimulus: Resetn=0 mid-count (Q=5, ovf=1); then Resetn=1 with en=0 for 3 cycles.
  - Required: Q=0, bnd=0, ovf=0 immediately, and Q stays 0.
- Wrap up:
  - Stimulus: sat=0, up=1, en=1 from Q=0 for 11 cycles.
  - Required: Q runs 1..9, 0, 1; bnd high only in the cycle after 9→0; ovf=1 thereafter.
- Saturate down:
  - Stimulus: sat=1, up=0, load din=2, then en=1 for 4 cycles.
  - Required: Q = 2, 1, 0, 0, 0; bnd high in each of the 2 cycles following the at-zero steps; ovf=1.
- Load clamp/priority:
  - Stimulus: load=1, en=1, din=14.
  - Required: Q=9, bnd=0.
  - Stimulus: then load=0, up=1, sat=0.
  - Required: Q=0, bnd=1.
- Limit lowered:
  - Stimulus: Q=8, set limit=3, up=1, en=1.
  - Required: sat=1 gives Q=3; sat=0 gives Q=0. bnd=1 in both.
  - Stimulus: Q=8, up=0.
  - Required: Q=7.
- ovf set/clear collision:
  - Stimulus: clr_ovf=1 in the same cycle as a boundary step.
  - Required: ovf=1.
  - Stimulus: next cycle clr_ovf=1, en=0.
  - Required: ovf=0, Q unchanged.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter over the range 0..limit with synchronous load,
// count enable, wrap or saturate at the range boundary, a registered boundary
// pulse and a sticky overflow flag.
module updown_mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic             bnd,
    output logic             ovf
);

    logic [WIDTH-1:0] q_next;
    logic             bnd_next;
    logic             ovf_next;
    logic             at_top;
    logic             at_bottom;

    // Boundary detection is done on the current value before any add or
    // subtract, so the arithmetic never needs a carry bit. A count left above
    // a lowered limit counts as being at the top.
    assign at_top    = (Q >= limit);
    assign at_bottom = (Q == '0);

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        q_next   = Q;
        bnd_next = 1'b0;
        if (load) begin
            q_next = (din > limit) ? limit : din;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    bnd_next = 1'b1;
                    q_next   = sat ? limit : '0;
                end else begin
                    q_next = Q + 1'b1;
                end
            end else begin
                if (at_bottom) begin
                    bnd_next = 1'b1;
                    q_next   = sat ? '0 : limit;
                end else begin
                    q_next = Q - 1'b1;
                end
            end
        end
        // A boundary in the same cycle as a clear keeps the flag set.
        if (bnd_next) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf;
        end
    end

    // Output registers; reset clears count, pulse and sticky flag at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q   <= '0;
            bnd <= 1'b0;
            ovf <= 1'b0;
        end else begin
            Q   <= q_next;
            bnd <= bnd_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         en, up, load, sat, clr_ovf;
    logic [W-1:0] din, limit;
    logic [W-1:0] Q;
    logic         bnd, ovf;

    int checks   = 0;
    int failures = 0;
    int m_q, m_bnd, m_ovf;

    updown_mod_counter #(.WIDTH(W)) dut (
        .Clock(Clock), .Resetn(Resetn), .en(en), .up(up), .load(load),
        .din(din), .limit(limit), .sat(sat), .clr_ovf(clr_ovf),
        .Q(Q), .bnd(bnd), .ovf(ovf)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv(input logic e, input logic u, input logic l, input int d,
                       input int lim, input logic s, input logic c);
        en = e; up = u; load = l; din = W'(d); limit = W'(lim); sat = s; clr_ovf = c;
    endtask

    // Reference: the counting rules evaluated on plain integers.
    task automatic model_step();
        int lim, nq, b;
        lim = int'(limit);
        nq  = m_q;
        b   = 0;
        if (load) begin
            nq = (int'(din) < lim) ? int'(din) : lim;
        end else if (en) begin
            if (up) begin
                if (m_q >= lim) begin b = 1; nq = sat ? lim : 0; end
                else nq = m_q + 1;
            end else begin
                if (m_q == 0) begin b = 1; nq = sat ? 0 : lim; end
                else nq = m_q - 1;
            end
        end
        if (b == 1) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        m_bnd = b;
        m_q   = nq;
    endtask

    // One clock: model follows the sampled inputs, outputs checked after the edge,
    // then return to the falling edge where the next inputs are driven.
    task automatic cycle(input string tag);
        @(posedge Clock);
        model_step();
        #1;
        check({tag, "_q"},   int'(Q),   m_q);
        check({tag, "_bnd"}, int'(bnd), m_bnd);
        check({tag, "_ovf"}, int'(ovf), m_ovf);
        @(negedge Clock);
    endtask

    initial begin
        Resetn = 1'b0;
        drv(0, 0, 0, 0, 9, 0, 0);
        m_q = 0; m_bnd = 0; m_ovf = 0;
        repeat (2) @(negedge Clock);
        check("rst_q", int'(Q), 0);
        check("rst_bnd", int'(bnd), 0);
        check("rst_ovf", int'(ovf), 0);
        Resetn = 1'b1;

        // Wrap up: 1..9, 0, 1 with bnd only after 9->0
        drv(1, 1, 0, 0, 9, 0, 0);
        for (int i = 0; i < 11; i++) begin
            cycle("wrap");
            check("wrap_seq", int'(Q), (i + 1) % 10);
        end

        // Park at 5 with ovf=1 then reset asynchronously mid-cycle
        drv(0, 1, 1, 5, 9, 0, 0);
        cycle("park");
        check("park_ovf", int'(ovf), 1);
        drv(1, 1, 0, 0, 9, 0, 0);
        #2;
        Resetn = 1'b0;
        #1;
        m_q = 0; m_bnd = 0; m_ovf = 0;
        check("arst_q", int'(Q), 0);
        check("arst_bnd", int'(bnd), 0);
        check("arst_ovf", int'(ovf), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        drv(0, 1, 0, 0, 9, 0, 0);
        for (int i = 0; i < 3; i++) cycle("hold");
        check("hold_q", int'(Q), 0);

        // Saturate down from 2
        drv(0, 0, 1, 2, 9, 1, 0);
        cycle("satld");
        drv(1, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 4; i++) cycle("satdn");
        check("satdn_q", int'(Q), 0);
        check("satdn_ovf", int'(ovf), 1);

        // Load clamp and priority over enable
        drv(1, 1, 1, 14, 9, 0, 0);
        cycle("clamp");
        check("clamp_q", int'(Q), 9);
        check("clamp_bnd", int'(bnd), 0);
        drv(1, 1, 0, 0, 9, 0, 0);
        cycle("clampwrap");
        check("clampwrap_q", int'(Q), 0);
        check("clampwrap_bnd", int'(bnd), 1);

        // Limit lowered below the count
        drv(0, 1, 1, 8, 9, 1, 0);  cycle("low_ld1");
        drv(1, 1, 0, 0, 3, 1, 0);  cycle("low_sat");
        check("low_sat_q", int'(Q), 3);
        drv(0, 1, 1, 8, 9, 0, 0);  cycle("low_ld2");
        drv(1, 1, 0, 0, 3, 0, 0);  cycle("low_wrap");
        check("low_wrap_q", int'(Q), 0);
        drv(0, 1, 1, 8, 9, 0, 0);  cycle("low_ld3");
        drv(1, 0, 0, 0, 3, 0, 0);  cycle("low_dn");
        check("low_dn_q", int'(Q), 7);

        // ovf set/clear collision
        drv(0, 0, 1, 0, 9, 0, 1);  cycle("col_ld");
        drv(1, 0, 0, 0, 9, 0, 1);  cycle("col_set");
        check("col_set_ovf", int'(ovf), 1);
        drv(0, 0, 0, 0, 9, 0, 1);  cycle("col_clr");
        check("col_clr_ovf", int'(ovf), 0);
        check("col_clr_q", int'(Q), 9);

        // limit = 0: every enabled step is a boundary
        drv(0, 1, 1, 0, 0, 0, 0);  cycle("lz_ld");
        drv(1, 1, 0, 0, 0, 0, 0);  cycle("lz_up");
        drv(1, 0, 0, 0, 0, 1, 0);  cycle("lz_dn");

        // Randomised traffic against the model
        begin
            int lim_r;
            lim_r = 9;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) lim_r = $urandom_range(0, 15);
                drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15), lim_r,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
                cycle("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
